// File: rtl/fpu_sched.sv
// Single-outstanding dispatch controller between the core and the shared FPU bank.
// Optional WAIT timeout is enabled by defining FPU_SCHED_TIMEOUT_EN.
module fpu_sched #(
    parameter int NUNIT   = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_unit,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [7:0]       req_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    output logic [31:0]      fpu_data_a,
    output logic [31:0]      fpu_data_b,
    output logic [7:0]       fpu_data_c,
    output logic [NUNIT-1:0] fpu_in_valid,
    input  logic [31:0]      fpu_out,
    input  logic             fpu_out_valid,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state, state_nx;
    logic       rdy_q;
    logic [3:0] unit_q;
    logic       accept, unit_ok, timeout_hit;

    localparam logic [NUNIT-1:0] ONE = {{(NUNIT-1){1'b0}}, 1'b1};

    // rdy_q holds req_ready low until the first edge after reset release
    assign req_ready    = (state == IDLE) && rdy_q;
    assign accept       = req_valid && req_ready;
    assign unit_ok      = int'(req_unit) < NUNIT;
    assign rsp_valid    = (state == DONE);
    assign busy         = (state != IDLE);
    assign fpu_in_valid = (state == ISSUE) ? (ONE << unit_q) : '0;

`ifdef FPU_SCHED_TIMEOUT_EN
    logic [15:0] wait_cnt;

    assign timeout_hit = (state == WAIT) && (wait_cnt == 16'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state == ISSUE)
            wait_cnt <= '0;
        else if (state == WAIT)
            wait_cnt <= wait_cnt + 16'd1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = unit_ok ? ISSUE : DONE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (fpu_out_valid || timeout_hit) state_nx = DONE;
            DONE:  if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nx;
            rdy_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit_q     <= '0;
            fpu_data_a <= '0;
            fpu_data_b <= '0;
            fpu_data_c <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                unit_q     <= req_unit;
                fpu_data_a <= req_a;
                fpu_data_b <= req_b;
                fpu_data_c <= req_c;
                if (!unit_ok) begin
                    rsp_err  <= 1'b1;
                    rsp_data <= '0;
                end
            end
            // a result arriving on the timeout cycle takes priority
            if (state == WAIT) begin
                if (fpu_out_valid) begin
                    rsp_data <= fpu_out;
                    rsp_err  <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_data <= 32'hFFFF_FFFF;
                    rsp_err  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fpu_sched.sv
// Directed bench for fpu_sched with a transaction-level reference model checked every cycle.
module tb_fpu_sched;
    localparam int NUNIT = 10;
    localparam int TMO   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0, req_ready;
    logic [3:0]       req_unit = '0;
    logic [31:0]      req_a = '0, req_b = '0;
    logic [7:0]       req_c = '0;
    logic             rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [31:0]      rsp_data, fpu_data_a, fpu_data_b, fpu_out = '0;
    logic [7:0]       fpu_data_c;
    logic [NUNIT-1:0] fpu_in_valid;
    logic             fpu_out_valid = 1'b0, busy;

    int checks = 0, errors = 0;

    fpu_sched #(.NUNIT(NUNIT), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_unit(req_unit),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .fpu_data_a(fpu_data_a), .fpu_data_b(fpu_data_b), .fpu_data_c(fpu_data_c),
        .fpu_in_valid(fpu_in_valid), .fpu_out(fpu_out), .fpu_out_valid(fpu_out_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one op in flight described by timestamps rather than states.
    bit          m_seen_edge, m_active, m_have_rsp;
    int          cyc, issue_cyc;
    logic [3:0]  m_unit;
    logic [31:0] m_a, m_b, m_data;
    logic [7:0]  m_c;
    logic        m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_seen_edge = 0; m_active = 0; m_have_rsp = 0;
            m_unit = 0; m_a = 0; m_b = 0; m_c = 0; m_data = 0; m_err = 0;
            issue_cyc = -100;
        end else begin
            if (m_seen_edge && !m_active && !m_have_rsp && req_valid) begin
                m_unit = req_unit; m_a = req_a; m_b = req_b; m_c = req_c;
                if (req_unit < NUNIT) begin
                    m_active = 1; issue_cyc = cyc + 1;
                end else begin
                    m_have_rsp = 1; m_data = 0; m_err = 1;
                end
            end else if (m_active && cyc > issue_cyc) begin
                if (fpu_out_valid) begin
                    m_active = 0; m_have_rsp = 1; m_data = fpu_out; m_err = 0;
                end
`ifdef FPU_SCHED_TIMEOUT_EN
                else if (cyc == issue_cyc + TMO + 1) begin
                    m_active = 0; m_have_rsp = 1; m_data = 32'hFFFF_FFFF; m_err = 1;
                end
`endif
            end else if (m_have_rsp && rsp_ready) begin
                m_have_rsp = 0;
            end
            m_seen_edge = 1;
        end
        if (rst_n) cyc++;
    end

    always @(negedge clk) begin
        logic [NUNIT-1:0] e_iv;
        e_iv = '0;
        if (m_active && cyc == issue_cyc) e_iv[m_unit] = 1'b1;
        chk("m_busy",      32'(busy),      32'(m_active || m_have_rsp));
        chk("m_req_ready", 32'(req_ready), 32'(m_seen_edge && !m_active && !m_have_rsp));
        chk("m_in_valid",  32'(fpu_in_valid), 32'(e_iv));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(m_have_rsp));
        chk("m_rsp_data",  rsp_data,       m_data);
        chk("m_rsp_err",   32'(rsp_err),   32'(m_err));
        chk("m_data_a",    fpu_data_a,     m_a);
        chk("m_data_b",    fpu_data_b,     m_b);
        chk("m_data_c",    32'(fpu_data_c), 32'(m_c));
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic send(input logic [3:0] u, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] c);
        req_valid = 1; req_unit = u; req_a = a; req_b = b; req_c = c;
        tick();
        req_valid = 0;
    endtask

    task automatic reply(input logic [31:0] d);
        fpu_out_valid = 1; fpu_out = d;
        tick();
        fpu_out_valid = 0;
    endtask

    initial begin
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_in_valid",  32'(fpu_in_valid), 0);
        chk("rst_rsp_data",  rsp_data, 0);
        tick(3);
        rst_n = 1;
        #1 chk("ready_before_edge", 32'(req_ready), 0);
        tick();
        chk("ready_after_edge", 32'(req_ready), 1);

        // basic op: strobe in cycle 1, reply four cycles later
        send(4'd3, 32'h3F80_0000, 32'h4000_0000, 8'h01);
        chk("basic_strobe", 32'(fpu_in_valid), 32'h008);
        chk("basic_a",      fpu_data_a, 32'h3F80_0000);
        tick();
        chk("basic_strobe_off", 32'(fpu_in_valid), 0);
        tick(3);
        reply(32'h4040_0000);
        chk("basic_rsp_valid", 32'(rsp_valid), 1);
        chk("basic_rsp_data",  rsp_data, 32'h4040_0000);
        chk("basic_rsp_err",   32'(rsp_err), 0);
        tick();
        chk("basic_idle", 32'(req_ready), 1);

        // bad index responds the next cycle without touching the FPU
        send(4'd12, 32'h1111_1111, 32'h2222_2222, 8'h33);
        chk("bad_rsp_valid", 32'(rsp_valid), 1);
        chk("bad_rsp_err",   32'(rsp_err), 1);
        chk("bad_rsp_data",  rsp_data, 0);
        chk("bad_in_valid",  32'(fpu_in_valid), 0);
        tick();

        // backpressure: response held, new request refused
        rsp_ready = 0;
        send(4'd0, 32'hA, 32'hB, 8'hC);
        tick();
        reply(32'h1234_5678);
        req_valid = 1; req_unit = 4'd5; req_a = 32'hDEAD;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rsp_data",  rsp_data, 32'h1234_5678);
            chk("bp_req_ready", 32'(req_ready), 0);
            tick();
        end
        req_valid = 0; rsp_ready = 1;
        tick();
        chk("bp_release_idle", 32'(busy), 0);
        chk("bp_not_accepted", fpu_data_a, 32'hA);

        // stray results in IDLE and DONE
        reply(32'hDEAD_BEEF);
        chk("stray_idle_busy", 32'(busy), 0);
        chk("stray_idle_data", rsp_data, 32'h1234_5678);
        rsp_ready = 0;
        send(4'd9, 32'h5, 32'h6, 8'h7);
        tick();
        reply(32'h0BAD_F00D);
        reply(32'hCAFE_CAFE);
        chk("stray_done_valid", 32'(rsp_valid), 1);
        chk("stray_done_data",  rsp_data, 32'h0BAD_F00D);
        rsp_ready = 1;
        tick();

        // async reset during WAIT, then a late result
        send(4'd2, 32'h77, 32'h88, 8'h99);
        tick();
        rst_n = 0;
        #1;
        chk("arst_in_valid",  32'(fpu_in_valid), 0);
        chk("arst_rsp_valid", 32'(rsp_valid), 0);
        chk("arst_busy",      32'(busy), 0);
        tick();
        rst_n = 1;
        tick();
        reply(32'h5555_5555);
        chk("arst_late_busy", 32'(busy), 0);
        chk("arst_late_data", rsp_data, 0);

`ifdef FPU_SCHED_TIMEOUT_EN
        begin
            int n;
            send(4'd1, 32'h1, 32'h2, 8'h3);
            n = 0;
            while (!rsp_valid && n < 40) begin tick(); n++; end
            chk("tmo_reached", 32'(n < 40), 1);
            chk("tmo_err",  32'(rsp_err), 1);
            chk("tmo_data", rsp_data, 32'hFFFF_FFFF);
            tick();
            send(4'd4, 32'h1, 32'h2, 8'h3);
            tick(TMO + 1);
            reply(32'h4242_4242);
            chk("tmo_race_err",  32'(rsp_err), 0);
            chk("tmo_race_data", rsp_data, 32'h4242_4242);
            tick();
        end
`endif

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_sched.md
# fpu_sched

Single-outstanding dispatch controller between the CPU core and the shared FPU bank. Accepts one FPU request at a time from the core and registers operands and per-op control byte. Issues a one-cycle, one-hot `fpu_in_valid` strobe to the selected unit, then waits for `fpu_out_valid` and returns the result through a valid/ready response port. Sits inside `top`, replacing direct core-to-FPU wiring; the external `fpu_*` pins connect straight to it.

## Interface
- `NUNIT`, 10: number of FPU units; width of `fpu_in_valid`.
- `TIMEOUT`, 1023: maximum WAIT cycles before error response (used only with the macro defined).
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core has a request.
- `req_ready` out 1: block accepts a request this cycle.
- `req_unit` in 4: target unit index, 0..NUNIT-1.
- `req_a` in 32: operand A.
- `req_b` in 32: operand B.
- `req_c` in 8: control byte (rounding/sub-op).
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: core consumes response.
- `rsp_data` out 32: result.
- `rsp_err` out 1: bad unit index or timeout.
- `fpu_data_a` out 32, `fpu_data_b` out 32, `fpu_data_c` out 8: registered operands to the FPU.
- `fpu_in_valid` out NUNIT: one-hot issue strobe.
- `fpu_out` in 32: FPU result.
- `fpu_out_valid` in 1: result strobe.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `req_a`, `req_b`, `req_c` and `req_unit`.
  - If `req_unit` < NUNIT, go to ISSUE.
  - Otherwise set `rsp_err`=1 and `rsp_data`=0, and go to DONE; the FPU is untouched.
- ISSUE:
  - `fpu_in_valid[unit]`=1 for exactly this cycle; all other bits 0.
  - Go to WAIT.
- WAIT:
  - `fpu_data_a`, `fpu_data_b` and `fpu_data_c` are held stable from ISSUE until leaving WAIT.
  - On `fpu_out_valid`, capture `fpu_out` into `rsp_data`, set `rsp_err`=0, and go to DONE.
- DONE:
  - `rsp_valid`=1; `rsp_data` and `rsp_err` are held stable.
  - On `rsp_ready`, go to IDLE.
- `fpu_out_valid` is ignored in IDLE, ISSUE and DONE: no capture and no state change.
- Reset values (async, immediate):
  - State IDLE.
  - `fpu_in_valid`=0, `rsp_valid`=0, `rsp_err`=0, `busy`=0.
  - `rsp_data`, `fpu_data_a`, `fpu_data_b` and `fpu_data_c` all 0.
  - `req_ready` goes high on the first clock edge after `rst_n` rises.
- Reset during ISSUE or WAIT abandons the op. A subsequent stray `fpu_out_valid` is ignored.

## Timing
- Request accepted at edge 0 → ISSUE strobe visible in cycle 1 → WAIT from cycle 2.
- `fpu_out_valid` sampled in cycle k ≥ 2 → `rsp_valid` in cycle k+1.
- Minimum request-to-response latency is 3 cycles.
- Bad-index response: `rsp_valid` in cycle 1.
- `rsp_ready` already high when DONE is entered: DONE lasts one cycle. IDLE follows in the next cycle, so back-to-back accept spacing is at least 4 cycles.
- `req_ready` is combinational from state only; there is no path from `req_valid` to `req_ready`.

## Configuration
- `FPU_SCHED_TIMEOUT_EN` defined:
  - 16-bit WAIT counter, cleared on ISSUE.
  - When the counter reaches TIMEOUT with no `fpu_out_valid`: `rsp_err`=1, `rsp_data`=32'hFFFFFFFF, go to DONE.
  - If `fpu_out_valid` arrives in the same cycle the timeout is reached, the result wins (no error).
- Not defined: no counter; WAIT persists until `fpu_out_valid`.

## Test plan
- **Basic op:** reset, `req_unit`=3, `req_a`=32'h3F800000, `req_b`=32'h40000000, `req_c`=8'h01; FPU returns 32'h40400000 four cycles after the strobe → `fpu_in_valid`=10'h008 for 1 cycle, operands stable, `rsp_data`=32'h40400000, `rsp_err`=0.
- **Bad index:** `req_unit`=12 → `rsp_valid` in cycle 1, `rsp_err`=1, `rsp_data`=0, `fpu_in_valid` never nonzero.
- **Response backpressure:** hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and `rsp_data` held; `req_ready`=0 and a new `req_valid` is not accepted; release → IDLE next cycle.
- **Stray result:** pulse `fpu_out_valid` while in IDLE and while in DONE → no state change, `rsp_data` unchanged.
- **Async reset mid-WAIT:** drop `rst_n` → `fpu_in_valid`, `rsp_valid` and `busy` are 0 without a clock edge; a late `fpu_out_valid` after release is ignored.
- **Timeout, with `FPU_SCHED_TIMEOUT_EN`:**
  - `TIMEOUT`=8, no FPU reply → `rsp_err`=1, `rsp_data`=32'hFFFFFFFF.
  - Reply arriving in the timeout cycle → normal result, `rsp_err`=0.
